// File: rtl/bf_pkg.sv
// bf_pkg -- shared definitions for the brainfuck machine.
//   Opcode byte constants (used by the loader and the CPU core), the loader
//   FSM state type, and an opcode membership helper.
package bf_pkg;

   localparam logic [7:0] OP_INC    = 8'h2B;  // '+'
   localparam logic [7:0] OP_DEC    = 8'h2D;  // '-'
   localparam logic [7:0] OP_LEFT   = 8'h3C;  // '<'
   localparam logic [7:0] OP_RIGHT  = 8'h3E;  // '>'
   localparam logic [7:0] OP_OPEN   = 8'h5B;  // '['
   localparam logic [7:0] OP_CLOSE  = 8'h5D;  // ']'
   localparam logic [7:0] OP_OUT    = 8'h2E;  // '.'
   localparam logic [7:0] OP_IN     = 8'h2C;  // ','
   localparam logic [7:0] OP_TERM   = 8'h00;  // end-of-program marker on the wire

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_PAD,
      S_DONE,
      S_ERR
   } state_t;

   function automatic logic is_opcode(input logic [7:0] b);
      return (b == OP_INC)  || (b == OP_DEC)   || (b == OP_LEFT) ||
             (b == OP_RIGHT)|| (b == OP_OPEN)  || (b == OP_CLOSE)||
             (b == OP_OUT)  || (b == OP_IN);
   endfunction

endpackage

// File: rtl/bf_uart_rx.sv
// bf_uart_rx -- 8N1 UART receiver with built-in 2-flop synchronizer.
//   clk        system clock (rising edge)
//   resetn     asynchronous active-low reset
//   rx         raw asynchronous serial line, idles high
//   byte_valid one-cycle pulse: byte_data holds a byte whose stop bit was 1
//   byte_data  received byte
//   frame_err  one-cycle pulse: a frame ended with a stop bit of 0
module bf_uart_rx #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

   rx_state_t     rstate;
   logic          rx_meta, rx_sync, rx_prev;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;

   // NOTE: all state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_meta    <= 1'b1;
         rx_sync    <= 1'b1;
         rx_prev    <= 1'b1;
         rstate     <= R_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         byte_valid <= 1'b0;
         byte_data  <= '0;
         frame_err  <= 1'b0;
      end else begin
         rx_meta    <= rx;
         rx_sync    <= rx_meta;
         rx_prev    <= rx_sync;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         cnt        <= cnt + CW'(1);
         case (rstate)
            R_IDLE: begin
               // Only a high-to-low transition starts a frame, so a line
               // stuck low after a bad frame does not retrigger.
               if (rx_prev && !rx_sync) begin
                  rstate <= R_START;
                  cnt    <= '0;
               end
            end
            R_START: begin
               if (cnt == HALF_BIT) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  rstate  <= rx_sync ? R_IDLE : R_DATA;
               end
            end
            R_DATA: begin
               if (cnt == FULL_BIT) begin
                  cnt     <= '0;
                  shreg   <= {rx_sync, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) rstate <= R_STOP;
               end
            end
            R_STOP: begin
               if (cnt == FULL_BIT) begin
                  rstate <= R_IDLE;
                  if (rx_sync) begin
                     byte_valid <= 1'b1;
                     byte_data  <= shreg;
                  end else begin
                     frame_err  <= 1'b1;
                  end
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/bf_uart_loader.sv
// bf_uart_loader -- loads a brainfuck program image over UART into program
// memory, filtering non-opcode bytes, checking bracket balance, and padding
// the remainder of memory with zeros after the 0x00 terminator.
//   clk, resetn   clock (rising edge), async active-low reset
//   load_req      one-cycle pulse: start or restart a load
//   rx            asynchronous UART line, 8N1
//   prog_we       program memory write strobe (one cycle per write)
//   prog_addr     program memory write address
//   prog_wr       program memory write data
//   loaded        program image complete and valid
//   load_err      sticky error flag, cleared by the next load_req
module bf_uart_loader
   import bf_pkg::*;
#(
   parameter int CLK_HZ          = 12000000,
   parameter int BAUD            = 115200,
   parameter int PROG_ADDR_WIDTH = 14,
   parameter int PROG_LEN        = 16383
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       load_req,
   input  logic                       rx,
   output logic                       prog_we,
   output logic [PROG_ADDR_WIDTH-1:0] prog_addr,
   output logic [7:0]                 prog_wr,
   output logic                       loaded,
   output logic                       load_err
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int AW = PROG_ADDR_WIDTH;
   localparam logic [AW-1:0] LAST_ADDR = AW'(PROG_LEN - 1);

   logic          byte_valid, frame_err;
   logic [7:0]    byte_data;
   state_t        state;
   logic [AW-1:0] wp, depth;
   // Set by the write of LAST_ADDR; avoids needing wp to hold PROG_LEN,
   // which may not fit in AW bits.
   logic          full;

   bf_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (clk),
      .resetn     (resetn),
      .rx         (rx),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .frame_err  (frame_err)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= S_IDLE;
         wp        <= '0;
         depth     <= '0;
         full      <= 1'b0;
         prog_we   <= 1'b0;
         prog_addr <= '0;
         prog_wr   <= '0;
         loaded    <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         prog_we <= 1'b0;
         if (load_req) begin
            // Restart wins over any byte or pad write due this cycle.
            state    <= S_RECV;
            wp       <= '0;
            depth    <= '0;
            full     <= 1'b0;
            loaded   <= 1'b0;
            load_err <= 1'b0;
         end else begin
            case (state)
               S_RECV: begin
                  if (full) begin
                     // Last location was written in the previous cycle.
                     if (depth == '0) begin
                        state  <= S_DONE;
                        loaded <= 1'b1;
                     end else begin
                        state    <= S_ERR;
                        load_err <= 1'b1;
                     end
                  end else if (frame_err) begin
                     state    <= S_ERR;
                     load_err <= 1'b1;
                  end else if (byte_valid) begin
                     if (byte_data == OP_TERM) begin
                        if (depth == '0) begin
                           state <= S_PAD;
                        end else begin
                           state    <= S_ERR;
                           load_err <= 1'b1;
                        end
                     end else if (is_opcode(byte_data)) begin
                        if (byte_data == OP_CLOSE && depth == '0) begin
                           state    <= S_ERR;
                           load_err <= 1'b1;
                        end else begin
                           prog_we   <= 1'b1;
                           prog_addr <= wp;
                           prog_wr   <= byte_data;
                           wp        <= wp + AW'(1);
                           if (wp == LAST_ADDR) full <= 1'b1;
                           if (byte_data == OP_OPEN)       depth <= depth + AW'(1);
                           else if (byte_data == OP_CLOSE) depth <= depth - AW'(1);
                        end
                     end
                  end
               end
               S_PAD: begin
                  if (full) begin
                     state  <= S_DONE;
                     loaded <= 1'b1;
                  end else begin
                     prog_we   <= 1'b1;
                     prog_addr <= wp;
                     prog_wr   <= 8'h00;
                     wp        <= wp + AW'(1);
                     if (wp == LAST_ADDR) full <= 1'b1;
                  end
               end
               default: ;  // S_IDLE, S_DONE, S_ERR wait for load_req
            endcase
         end
      end
   end

endmodule

// File: doc/bf_uart_loader.md
BF_UART_LOADER -- requirements
Module: bf_uart_loader

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12000000, meaning system clock frequency.
REQ-002 SHALL have parameter BAUD, default 115200, meaning UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer division (104 at the defaults).
REQ-003 SHALL have parameter PROG_ADDR_WIDTH, default 14, meaning program address width.
REQ-004 SHALL have parameter PROG_LEN, default 16383, meaning number of program memory locations written (addresses 0..PROG_LEN-1).
REQ-005 clk  input  1  system clock; all logic is on the rising edge.
REQ-006 resetn  input  1  reset, asynchronous, active-low.
REQ-007 load_req  input  1  single-cycle pulse that starts or restarts a load.
REQ-008 rx  input  1  asynchronous UART line, 8N1, idles high.
REQ-009 prog_we  output  1  program memory write strobe, one cycle per write.
REQ-010 prog_addr  output  PROG_ADDR_WIDTH  program memory write address.
REQ-011 prog_wr  output  8  program memory write data.
REQ-012 loaded  output  1  high when the program image is complete and valid.
REQ-013 load_err  output  1  sticky error flag, cleared by the next load_req.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-015 UART RX: start is a falling edge in idle; start bit re-checked low at CLKS_PER_BIT/2 (else return to idle, no byte); 8 data bits LSB first, each sampled CLKS_PER_BIT after the previous sample; stop bit sampled one bit later.
REQ-016 UART RX SHALL emit a byte_valid pulse (1 cycle) with byte_data when stop=1; it SHALL emit frame_err (1 cycle) when stop=0.
REQ-017 Main FSM states: S_IDLE, S_RECV, S_PAD, S_DONE, S_ERR.
REQ-018 S_IDLE/S_DONE/S_ERR + load_req -> S_RECV; SHALL clear write pointer wp=0, bracket depth=0, loaded=0, load_err=0.
REQ-019 S_RECV + byte in {+ - < > [ ] . ,} (0x2B 0x2D 0x3C 0x3E 0x5B 0x5D 0x2E 0x2C) SHALL write it: prog_we=1, prog_addr=wp, prog_wr=byte, in the cycle after byte_valid; then wp increments.
REQ-020 S_RECV + any other nonzero byte SHALL be discarded without a write.
REQ-021 '[' SHALL increment depth; ']' at depth>0 SHALL decrement depth; ']' at depth 0 SHALL NOT be written and SHALL go to S_ERR.
REQ-022 S_RECV + byte 0x00 (terminator) -> S_PAD if depth==0, else S_ERR.
REQ-023 When the write of address PROG_LEN-1 completes, the FSM SHALL leave S_RECV: -> S_DONE if depth==0, else S_ERR; later bytes are ignored.
REQ-024 S_PAD SHALL write 0x00 to addresses wp..PROG_LEN-1, one per cycle, back to back, then -> S_DONE.
REQ-025 Entering S_DONE SHALL set loaded=1 on the cycle after the final write.
REQ-026 S_RECV + frame_err -> S_ERR.
REQ-027 Entering S_ERR SHALL set load_err=1; loaded stays 0.
REQ-028 load_req in S_RECV or S_PAD SHALL restart as REQ-018; any write due in that cycle SHALL be suppressed.
REQ-029 A load_req coinciding with byte_valid SHALL take priority; the byte is dropped.
REQ-030 prog_we SHALL be 0 in S_IDLE, S_DONE and S_ERR.
REQ-031 depth and wp SHALL be PROG_ADDR_WIDTH bits; depth cannot overflow because depth <= wp < PROG_LEN.

Reset
REQ-032 On resetn low: FSM=S_IDLE, RX=idle, synchronizer=1, prog_we=0, prog_addr=0, prog_wr=0, loaded=0, load_err=0, wp=0, depth=0.
REQ-033 Reset mid-load SHALL abandon the load; the memory contents are undefined until the next complete load.

Structure
REQ-034 Opcode byte constants and the main FSM state_t enum SHALL live in shared package bf_pkg; the CPU core SHALL use the same opcode constants.
REQ-035 The UART receiver SHALL be sub-module bf_uart_rx (ports: clk, resetn, rx, byte_valid, byte_data, frame_err), parameterized by CLKS_PER_BIT.

Verification
REQ-036 Defaults; load_req, send "+[-]." then 0x00 -> writes 0:2B 1:5B 2:2D 3:5D 4:2E; zeros at 5..16382; loaded=1; load_err=0.
REQ-037 Send "a+\nb>" then 0x00 -> exactly 2 data writes, 0:2B 1:3E, then padding; loaded=1.
REQ-038 Send "]" -> no write; load_err=1; loaded=0. A new load_req clears load_err.
REQ-039 Send "[[]" then 0x00 -> 3 writes; load_err=1; no padding writes.
REQ-040 Byte 0x41 with stop bit driven 0 -> load_err=1. Separately, a 20-cycle low glitch on rx -> no byte and no error.
REQ-041 PROG_LEN=8, send "++++++++++" -> writes to 0..7 only; loaded=1; later bytes produce no writes. load_req mid-S_PAD -> restart at wp=0 with loaded=0.
